// File: rtl/uart_tx_ser_if.sv
// FIFO-side handshake between a depth-1 upstream FIFO and the UART serializer.
// The master drives data/occupancy and the slave (serializer) returns the pop strobe.
interface uart_tx_ser_if #(
  parameter int width = 8
);
  logic [width-1:0] D_IN;
  logic             EMPTY_N;
  logic             DEQ;

  modport master (output D_IN, output EMPTY_N, input DEQ);
  modport slave  (input D_IN, input EMPTY_N, output DEQ);
endinterface

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pops frames from a depth-1 FIFO and shifts them out LSB first.
// Define UART_TX_PARITY_EN to append an even-parity bit between the data and stop bits.
module uart_tx_ser #(
  parameter int width        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  uart_tx_ser_if.slave     fifo,
  output logic             TXD,
  output logic             BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(width);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    bit_idx, idx_n;
  logic [width-1:0] shreg, shreg_n;
  logic             txd_n;
  logic             deq_c;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_n;
`endif

  assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign fifo.DEQ = deq_c & RST_N;

  // next-state, counters and the pop strobe
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    idx_n   = bit_idx;
    deq_c   = 1'b0;
    if (state != IDLE) begin
      cnt_n = bit_end ? '0 : cnt + CW'(1);
    end
    case (state)
      IDLE: begin
        if (fifo.EMPTY_N) begin
          deq_c   = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == IW'(width - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = bit_idx + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (fifo.EMPTY_N) begin
            deq_c   = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // shift register advances only when a data bit has been held for its full time
  always_comb begin
    shreg_n = shreg;
    if (deq_c) begin
      shreg_n = fifo.D_IN;
    end else if (state == DATA && bit_end) begin
      shreg_n = shreg >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    par_n = par_q;
    if (deq_c) par_n = ^fifo.D_IN;
  end
`endif

  // TXD is registered, so its next value follows the state being entered
  always_comb begin
    txd_n = 1'b1;
    case (state_n)
      START:  txd_n = 1'b0;
      DATA:   txd_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_n = par_n;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      TXD     <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= idx_n;
      TXD     <= txd_n;
      BUSY    <= (state_n != IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    shreg <= shreg_n;
`ifdef UART_TX_PARITY_EN
    par_q <= par_n;
`endif
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Scoreboard bench for uart_tx_ser: every DEQ pushes the expected per-cycle line levels,
// and each cycle pops one and compares TXD, BUSY and the expected DEQ.
module tb_uart_tx_ser;
  localparam int CPB = 4;
  localparam int W   = 8;

  logic CLK;
  logic RST_N;
  logic TXD;
  logic BUSY;

  uart_tx_ser_if #(.width(W)) bus ();

  uart_tx_ser #(.width(W), .CLKS_PER_BIT(CPB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .fifo  (bus.slave),
    .TXD   (TXD),
    .BUSY  (BUSY)
  );

  int total = 0;
  int bad   = 0;

  logic         exp_q[$];
  logic [W-1:0] src_q[$];
  logic         deq_pend = 1'b0;
  logic         tog      = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[k]);
    end
  endtask

  // per-cycle scoreboard check, sampled away from the active edge
  always @(negedge CLK) begin
    logic e;
    if (!RST_N) begin
      exp_q.delete();
      deq_pend = 1'b0;
      chk("rst_txd", {31'd0, TXD}, 32'd1);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_deq", {31'd0, bus.DEQ}, 32'd0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("txd", {31'd0, TXD}, {31'd0, e});
        chk("busy", {31'd0, BUSY}, 32'd1);
      end else begin
        chk("idle_txd", {31'd0, TXD}, 32'd1);
        chk("idle_busy", {31'd0, BUSY}, 32'd0);
      end
      chk("deq", {31'd0, bus.DEQ}, {31'd0, (bus.EMPTY_N && exp_q.size() == 0)});
      if (bus.DEQ) begin
        push_frame(bus.D_IN);
        deq_pend = 1'b1;
      end
    end
  end

  task automatic drive();
    bus.EMPTY_N = (src_q.size() > 0) || tog;
    bus.D_IN    = (src_q.size() > 0) ? src_q[0] : 8'hFF;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (deq_pend) begin
      void'(src_q.pop_front());
      deq_pend = 1'b0;
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((exp_q.size() != 0 || src_q.size() != 0) && n < max);
    chk("timeout", {31'd0, (exp_q.size() == 0 && src_q.size() == 0)}, 32'd1);
    run(3);
  endtask

  initial begin
    RST_N = 1'b0;
    drive();
    run(3);
    RST_N = 1'b1;

    // idle line with empty FIFO
    run(50);

    // single frame
    src_q.push_back(8'hA5);
    drive();
    wait_idle(200);

    // back-to-back frames, second popped on the final stop cycle
    src_q.push_back(8'h00);
    src_q.push_back(8'hFF);
    drive();
    wait_idle(300);

    // parity-relevant patterns
    src_q.push_back(8'h07);
    src_q.push_back(8'h03);
    drive();
    wait_idle(300);

    // EMPTY_N wiggling mid-frame must not pop or disturb bits
    src_q.push_back(8'h5A);
    drive();
    run(8);
    for (int i = 0; i < 20; i++) begin
      tog = ~tog;
      step();
    end
    tog = 1'b0;
    drive();
    wait_idle(200);

    // reset during a frame
    src_q.push_back(8'h3C);
    drive();
    step();
    run(16);
    #1;
    RST_N = 1'b0;
    src_q.delete();
    tog = 1'b0;
    drive();
    #1;
    chk("rst_async_txd", {31'd0, TXD}, 32'd1);
    chk("rst_async_busy", {31'd0, BUSY}, 32'd0);
    run(3);
    RST_N = 1'b1;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
